pll_clk_rst_mgr: RTL

Clock/reset manager that sits directly behind the PLL, in the PLL output clock domain, and gates the rest of the design on PLL health. It synchronises the asynchronous PLL lock flag and releases the core reset only after lock has been continuously stable for a programmable settle time. It re-asserts the core reset on lock loss or on a software request and counts lock-loss events. It also provides NUM_TICKS independent, runtime-programmable clock-enable strobes (baud/sample ticks) that are active only while the core is out of reset.

---
 rtl/pll_clk_rst_mgr_pkg.sv | 12 +
 rtl/pll_clk_rst_mgr_tick_div.sv | 41 ++++
 rtl/pll_clk_rst_mgr.sv | 100 ++++++++++
 3 files changed

// File: rtl/pll_clk_rst_mgr_pkg.sv
// Shared types for the PLL clock/reset manager: FSM state encoding.
package pll_clk_rst_mgr_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/pll_clk_rst_mgr_tick_div.sv
// Programmable clock-enable divider: one-cycle registered strobe every div_i enabled cycles.
module tick_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  // cnt+1 >= div in one extra bit: div of 0 or 1 wraps every cycle, and a
  // divisor lowered below the running count wraps immediately.
  assign wrap = ({1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1}) >= {1'b0, div_i};

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en_i) begin
      tick_d = wrap;
      cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pll_clk_rst_mgr.sv
// PLL-domain reset manager: lock synchroniser, settle FSM, lock-loss counter, tick strobes.
module pll_clk_rst_mgr
  import pll_clk_rst_mgr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned NUM_TICKS   = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       pll_locked_i,
  input  logic                       rst_req_i,
  input  logic [NUM_TICKS*DIV_W-1:0] tick_div_i,
  output logic                       sys_rst_no,
  output logic [NUM_TICKS-1:0]       tick_o,
  output logic [LOSS_CNT_W-1:0]      loss_cnt_o,
  output logic [STATE_W-1:0]         state_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       settle_q, settle_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   sys_rst_q;
  logic                   run_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    loss_d   = loss_q;
    case (state_q)
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss takes priority over a coincident software request.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
        end else if (rst_req_i) begin
          state_d = SETTLE;
        end
      end
      default: state_d = lock_s ? SETTLE : WAIT_LOCK;
    endcase
  end

  assign run_next = (state_d == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WAIT_LOCK;
      settle_q  <= '0;
      loss_q    <= '0;
      sys_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      loss_q    <= loss_d;
      sys_rst_q <= run_next;
    end
  end

  // Dividers are enabled from next-state so their registered strobes align with sys_rst_no.
  for (genvar k = 0; k < NUM_TICKS; k++) begin : g_tick
    tick_div #(
      .DIV_W(DIV_W)
    ) u_tick_div (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (run_next),
      .div_i (tick_div_i[k*DIV_W +: DIV_W]),
      .tick_o(tick_o[k])
    );
  end

  assign sys_rst_no = sys_rst_q;
  assign loss_cnt_o = loss_q;
  assign state_o    = state_q;

endmodule
